// File: rtl/relay_station_pkg.sv
// Shared definitions for the credit-based relay station.
//   calc_fifo_depth : receive FIFO depth = slack + round-trip cover
//   calc_credit_w   : counter width able to hold 0..FIFO_DEPTH
//   credit_op_e     : per-cycle action applied to the sender credit counter
package relay_station_pkg;

  // Round trip is LEVEL forward stages + LEVEL return stages, plus one cycle
  // each for the FIFO push register and the credit counter register.
  function automatic int calc_fifo_depth(input int depth, input int level);
    return depth + 2 * level + 2;
  endfunction

  function automatic int calc_credit_w(input int fifo_depth);
    return $clog2(fifo_depth + 1);
  endfunction

  typedef enum logic [1:0] {
    CREDIT_HOLD   = 2'd0,
    CREDIT_TAKE   = 2'd1,
    CREDIT_RETURN = 2'd2
  } credit_op_e;

endpackage

// File: rtl/relay_fifo_fwft.sv
// First-word-fall-through receive FIFO for the relay station.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   if_write_ce, if_write   push request (both must be high)
//   if_din                  push payload
//   if_empty_n              head word valid on if_dout
//   if_read_ce, if_read     pop request (both must be high, ignored when empty)
//   if_dout                 registered head-of-FIFO payload
//   overflow                sticky: push arrived while full with no same-cycle pop
module relay_fifo_fwft #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [AW-1:0]         wr_ptr_inc, rd_ptr_inc;
  logic [CW-1:0]         count_reg, count_next;
  logic [DATA_WIDTH-1:0] head_reg, head_next;
  logic                  overflow_reg;
  logic                  push_req, push, pop, full;

  // Depth need not be a power of two, so pointers wrap explicitly.
  assign wr_ptr_inc = (wr_ptr_reg == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
  assign rd_ptr_inc = (rd_ptr_reg == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;

  assign full     = (count_reg == CW'(FIFO_DEPTH));
  assign push_req = if_write & if_write_ce;
  assign pop      = if_read & if_read_ce & (count_reg != '0);
  // A pop frees the slot in the same cycle, so push at full is legal with pop.
  assign push     = push_req & (~full | pop);

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // head_reg always mirrors mem[rd_ptr_reg]; it is refreshed one cycle early
  // so the next head is already on if_dout when the pointer moves.
  always_comb begin
    head_next = head_reg;
    if (push && ((count_reg == '0) || (pop && (count_reg == CW'(1))))) begin
      head_next = if_din;
    end else if (pop && (count_reg > CW'(1))) begin
      head_next = mem[rd_ptr_inc];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= if_din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      head_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_inc;
      if (pop)  rd_ptr_reg <= rd_ptr_inc;
      count_reg <= count_next;
      head_reg  <= head_next;
      if (push_req && full && !pop) overflow_reg <= 1'b1;
    end
  end

  assign if_empty_n = (count_reg != '0);
  assign if_dout    = head_reg;
  assign overflow   = overflow_reg;

endmodule

// File: rtl/relay_station_credit.sv
// Credit-based relay station: a sender-side credit counter, LEVEL register
// stages forward (payload) and LEVEL stages back (credits), and a FWFT
// receive FIFO sized to cover the full credit round trip plus DEPTH slack.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   if_full_n                write side: credit available
//   if_write_ce, if_write    write qualifier / request
//   if_din                   write payload
//   if_empty_n               read side: word valid on if_dout
//   if_read_ce, if_read      read qualifier / request
//   if_dout                  head-of-FIFO payload
//   credit_cnt               current sender credit count
//   err_overflow             sticky receive-FIFO overflow flag
module relay_station_credit
  import relay_station_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 2,
  parameter  int LEVEL      = 2,
  localparam int FIFO_DEPTH = calc_fifo_depth(DEPTH, LEVEL),
  localparam int CREDIT_W   = calc_credit_w(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic [CREDIT_W-1:0]   credit_cnt,
  output logic                  err_overflow
);

  logic                  accept, pop;
  logic                  push, credit_ret;
  logic [DATA_WIDTH-1:0] push_data;
  logic [CREDIT_W-1:0]   credit_reg, credit_next;
  logic                  full_n_reg;
  credit_op_e            credit_op;

  assign accept = if_write & if_write_ce & full_n_reg;
  assign pop    = if_read & if_read_ce & if_empty_n;

  // Forward {valid,data} and return credit pipelines.
  if (LEVEL == 0) begin : g_comb
    assign push       = accept;
    assign push_data  = if_din;
    assign credit_ret = pop;
  end else begin : g_pipe
    logic                  fwd_valid_reg [LEVEL];
    logic [DATA_WIDTH-1:0] fwd_data_reg  [LEVEL];
    logic                  ret_valid_reg [LEVEL];

    for (genvar gi = 0; gi < LEVEL; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (reset) begin
            fwd_valid_reg[gi] <= 1'b0;
            ret_valid_reg[gi] <= 1'b0;
          end else begin
            fwd_valid_reg[gi] <= accept;
            ret_valid_reg[gi] <= pop;
          end
          fwd_data_reg[gi] <= if_din;
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (reset) begin
            fwd_valid_reg[gi] <= 1'b0;
            ret_valid_reg[gi] <= 1'b0;
          end else begin
            fwd_valid_reg[gi] <= fwd_valid_reg[gi-1];
            ret_valid_reg[gi] <= ret_valid_reg[gi-1];
          end
          fwd_data_reg[gi] <= fwd_data_reg[gi-1];
        end
      end
    end

    assign push       = fwd_valid_reg[LEVEL-1];
    assign push_data  = fwd_data_reg[LEVEL-1];
    assign credit_ret = ret_valid_reg[LEVEL-1];
  end

  // Simultaneous take and return cancel out. The bounds guards keep the
  // counter inside 0..FIFO_DEPTH even if the return path misbehaves.
  always_comb begin
    credit_op = CREDIT_HOLD;
    if (accept && !credit_ret) begin
      credit_op = CREDIT_TAKE;
    end else if (credit_ret && !accept) begin
      credit_op = CREDIT_RETURN;
    end
    credit_next = credit_reg;
    case (credit_op)
      CREDIT_TAKE: begin
        if (credit_reg != '0) credit_next = credit_reg - 1'b1;
      end
      CREDIT_RETURN: begin
        if (credit_reg != CREDIT_W'(FIFO_DEPTH)) credit_next = credit_reg + 1'b1;
      end
      default: credit_next = credit_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credit_reg <= CREDIT_W'(FIFO_DEPTH);
      full_n_reg <= 1'b1;
    end else begin
      credit_reg <= credit_next;
      full_n_reg <= (credit_next != '0);
    end
  end

  relay_fifo_fwft #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .if_write_ce (1'b1),
    .if_write    (push),
    .if_din      (push_data),
    .if_empty_n  (if_empty_n),
    .if_read_ce  (if_read_ce),
    .if_read     (if_read),
    .if_dout     (if_dout),
    .overflow    (err_overflow)
  );

  assign if_full_n  = full_n_reg;
  assign credit_cnt = credit_reg;

endmodule

// File: tb/tb_relay_station_credit.sv
// Directed self-checking bench for relay_station_credit at
// DATA_WIDTH=32, DEPTH=2, LEVEL=2 (FIFO_DEPTH=8, credit width 4).
// "Cycle n" is the interval after the n-th rising edge; outputs are
// sampled 1 time unit after each rising edge.
module tb_relay_station_credit;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_full_n;
  logic        if_write_ce;
  logic        if_write;
  logic [31:0] if_din;
  logic        if_empty_n;
  logic        if_read_ce;
  logic        if_read;
  logic [31:0] if_dout;
  logic [3:0]  credit_cnt;
  logic        err_overflow;

  int checks = 0;
  int errors = 0;

  relay_station_credit #(
    .DATA_WIDTH (32),
    .DEPTH      (2),
    .LEVEL      (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .if_full_n    (if_full_n),
    .if_write_ce  (if_write_ce),
    .if_write     (if_write),
    .if_din       (if_din),
    .if_empty_n   (if_empty_n),
    .if_read_ce   (if_read_ce),
    .if_read      (if_read),
    .if_dout      (if_dout),
    .credit_cnt   (credit_cnt),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    if_write = 1'b0;
    if_read  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (credit_cnt !== 4'd8) begin errors++; $display("FAIL reset_credit got %0d want 8", credit_cnt); end
    checks++; if (if_full_n !== 1'b1) begin errors++; $display("FAIL reset_full_n got %b want 1", if_full_n); end
    checks++; if (if_empty_n !== 1'b0) begin errors++; $display("FAIL reset_empty_n got %b want 0", if_empty_n); end
    checks++; if (if_dout !== 32'h0) begin errors++; $display("FAIL reset_dout got %h want 0", if_dout); end
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", err_overflow); end
    $display("test_reset: credit=%0d full_n=%b empty_n=%b", credit_cnt, if_full_n, if_empty_n);
  endtask

  task automatic test_latency();
    do_reset();
    if_read  = 1'b1;
    if_write = 1'b1;
    if_din   = 32'hA5;                                    // cycle 0
    tick(); if_write = 1'b0;                              // cycle 1
    checks++; if (credit_cnt !== 4'd7) begin errors++; $display("FAIL lat_credit_c1 got %0d want 7", credit_cnt); end
    checks++; if (if_empty_n !== 1'b0) begin errors++; $display("FAIL lat_empty_c1 got %b want 0", if_empty_n); end
    tick();                                               // cycle 2
    checks++; if (if_empty_n !== 1'b0) begin errors++; $display("FAIL lat_empty_c2 got %b want 0", if_empty_n); end
    tick();                                               // cycle 3
    checks++; if (if_empty_n !== 1'b1) begin errors++; $display("FAIL lat_empty_c3 got %b want 1", if_empty_n); end
    checks++; if (if_dout !== 32'hA5) begin errors++; $display("FAIL lat_dout_c3 got %h want a5", if_dout); end
    tick();                                               // cycle 4
    checks++; if (if_empty_n !== 1'b0) begin errors++; $display("FAIL lat_empty_c4 got %b want 0", if_empty_n); end
    tick();                                               // cycle 5
    checks++; if (credit_cnt !== 4'd7) begin errors++; $display("FAIL lat_credit_c5 got %0d want 7", credit_cnt); end
    tick();                                               // cycle 6
    checks++; if (credit_cnt !== 4'd8) begin errors++; $display("FAIL lat_credit_c6 got %0d want 8", credit_cnt); end
    if_read = 1'b0;
    $display("test_latency: word a5 out at cycle 3, credit=%0d at cycle 6", credit_cnt);
  endtask

  // Leaves the FIFO full with 0x100..0x107 and zero credit.
  task automatic test_fill();
    int acc = 0;
    do_reset();
    if_read  = 1'b0;
    if_write = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if_din = 32'h100 + acc;
      if (if_full_n) acc++;
      tick();
    end
    if_write = 1'b0;
    checks++; if (acc !== 8) begin errors++; $display("FAIL fill_accepts got %0d want 8", acc); end
    checks++; if (if_full_n !== 1'b0) begin errors++; $display("FAIL fill_full_n got %b want 0", if_full_n); end
    checks++; if (credit_cnt !== 4'd0) begin errors++; $display("FAIL fill_credit got %0d want 0", credit_cnt); end
    tick(); tick(); tick();
    checks++; if (if_empty_n !== 1'b1 || if_dout !== 32'h100) begin errors++; $display("FAIL fill_head got %b/%h want 1/100", if_empty_n, if_dout); end
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL fill_overflow got %b want 0", err_overflow); end
    $display("test_fill: accepted %0d words, full_n=%b", acc, if_full_n);
  endtask

  task automatic test_refill();
    int acc = 0;
    int k = 0;
    logic [31:0] exp_word;
    if_write = 1'b1;
    if_din   = 32'h200;
    if_read  = 1'b1;                                      // cycle t: single pop
    tick(); if_read = 1'b0;                               // t+1
    checks++; if (if_full_n !== 1'b0) begin errors++; $display("FAIL refill_full_t1 got %b want 0", if_full_n); end
    checks++; if (if_dout !== 32'h101) begin errors++; $display("FAIL refill_head_t1 got %h want 101", if_dout); end
    tick();                                               // t+2
    checks++; if (if_full_n !== 1'b0) begin errors++; $display("FAIL refill_full_t2 got %b want 0", if_full_n); end
    tick();                                               // t+3
    checks++; if (if_full_n !== 1'b1) begin errors++; $display("FAIL refill_full_t3 got %b want 1", if_full_n); end
    for (int i = 0; i < 8; i++) begin
      if (if_full_n) acc++;
      tick();
    end
    if_write = 1'b0;
    checks++; if (acc !== 1) begin errors++; $display("FAIL refill_accepts got %0d want 1", acc); end
    if_read = 1'b1;
    for (int i = 0; i < 20 && k < 8; i++) begin
      if (if_empty_n) begin
        exp_word = (k < 7) ? 32'h101 + k : 32'h200;
        checks++; if (if_dout !== exp_word) begin errors++; $display("FAIL refill_order[%0d] got %h want %h", k, if_dout, exp_word); end
        k++;
      end
      tick();
    end
    if_read = 1'b0;
    checks++; if (k !== 8) begin errors++; $display("FAIL refill_drain_count got %0d want 8", k); end
    $display("test_refill: %0d extra accepted, %0d words drained", acc, k);
  endtask

  task automatic test_stream();
    int sent = 0;
    int recv = 0;
    int cyc = 0;
    do_reset();
    if_read = 1'b1;
    while (recv < 100 && cyc < 400) begin
      if (sent < 100) begin
        if_write = 1'b1;
        if_din   = sent;
      end else begin
        if_write = 1'b0;
      end
      if (if_empty_n) begin
        checks++; if (if_dout !== recv) begin errors++; $display("FAIL stream_word got %0d want %0d", if_dout, recv); end
        recv++;
      end else if (recv > 0) begin
        checks++; errors++; $display("FAIL stream_gap got empty at word %0d want valid", recv);
      end
      if (if_write && if_full_n) sent++;
      tick();
      cyc++;
    end
    if_write = 1'b0;
    if_read  = 1'b0;
    checks++; if (recv !== 100) begin errors++; $display("FAIL stream_count got %0d want 100", recv); end
    checks++; if (cyc !== 103) begin errors++; $display("FAIL stream_cycles got %0d want 103", cyc); end
    $display("test_stream: %0d words in %0d cycles", recv, cyc);
  endtask

  task automatic test_credit_equal();
    do_reset();
    if_read  = 1'b0;
    if_write = 1'b1;
    if_din   = 32'h55;
    for (int i = 0; i < 7; i++) tick();
    if_write = 1'b0;
    tick(); tick(); tick();
    checks++; if (credit_cnt !== 4'd1) begin errors++; $display("FAIL eq_credit_pre got %0d want 1", credit_cnt); end
    if_read = 1'b1;                                       // pop at t
    tick(); if_read = 1'b0;                               // t+1
    tick();                                               // t+2: credit returns at this edge
    if_write = 1'b1;
    if_din   = 32'h66;
    checks++; if (if_full_n !== 1'b1 || credit_cnt !== 4'd1) begin errors++; $display("FAIL eq_pre_accept got %b/%0d want 1/1", if_full_n, credit_cnt); end
    tick(); if_write = 1'b0;                              // t+3
    checks++; if (credit_cnt !== 4'd1) begin errors++; $display("FAIL eq_credit got %0d want 1", credit_cnt); end
    checks++; if (if_full_n !== 1'b1) begin errors++; $display("FAIL eq_full_n got %b want 1", if_full_n); end
    tick();
    checks++; if (credit_cnt !== 4'd1) begin errors++; $display("FAIL eq_credit_hold got %0d want 1", credit_cnt); end
    $display("test_credit_equal: credit=%0d full_n=%b", credit_cnt, if_full_n);
  endtask

  task automatic test_reset_midflight();
    int stale = 0;
    do_reset();
    if_read  = 1'b0;
    if_write = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if_din = 32'h300 + i;
      tick();
    end
    // Reset while words 3 and 4 are still in the pipeline, with a
    // simultaneous write and read request that must both be ignored.
    reset    = 1'b1;
    if_din   = 32'hDEAD;
    if_read  = 1'b1;
    tick();
    reset    = 1'b0;
    if_write = 1'b0;
    checks++; if (if_empty_n !== 1'b0) begin errors++; $display("FAIL mid_empty_n got %b want 0", if_empty_n); end
    checks++; if (credit_cnt !== 4'd8) begin errors++; $display("FAIL mid_credit got %0d want 8", credit_cnt); end
    checks++; if (if_full_n !== 1'b1) begin errors++; $display("FAIL mid_full_n got %b want 1", if_full_n); end
    checks++; if (if_dout !== 32'h0) begin errors++; $display("FAIL mid_dout got %h want 0", if_dout); end
    for (int i = 0; i < 10; i++) begin
      if (if_empty_n) stale++;
      tick();
    end
    if_read = 1'b0;
    checks++; if (stale !== 0) begin errors++; $display("FAIL mid_stale got %0d want 0", stale); end
    checks++; if (credit_cnt !== 4'd8) begin errors++; $display("FAIL mid_credit_after got %0d want 8", credit_cnt); end
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow got %b want 0", err_overflow); end
    $display("test_reset_midflight: stale=%0d credit=%0d", stale, credit_cnt);
  endtask

  initial begin
    reset       = 1'b1;
    if_write_ce = 1'b1;
    if_write    = 1'b0;
    if_din      = '0;
    if_read_ce  = 1'b1;
    if_read     = 1'b0;
    test_reset();
    test_latency();
    test_fill();
    test_refill();
    test_stream();
    test_credit_equal();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/relay_station_credit.md
RELAY_STATION_CREDIT -- requirements
Module: relay_station_credit

Interface
REQ-001 Parameter DATA_WIDTH, default 32: payload width in bits.
REQ-002 Parameter DEPTH, default 2: extra receive-FIFO slack beyond round-trip cover.
REQ-003 Parameter LEVEL, default 2: pipeline register stages in each direction, 0 allowed.
REQ-004 Derived FIFO_DEPTH = DEPTH + 2*LEVEL + 2; CREDIT_W = $clog2(FIFO_DEPTH+1).
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 if_full_n  output  1  write side: credit available, write may be accepted.
REQ-008 if_write_ce, if_write  input  1 each  write qualifier and write request.
REQ-009 if_din  input  DATA_WIDTH  write payload.
REQ-010 if_empty_n  output  1  read side: FWFT word valid on if_dout.
REQ-011 if_read_ce, if_read  input  1 each  read qualifier and read request.
REQ-012 if_dout  output  DATA_WIDTH  head-of-FIFO payload.
REQ-013 credit_cnt  output  CREDIT_W  current sender credit count.
REQ-014 err_overflow  output  1  sticky: write arrived at a full receive FIFO.

Function
REQ-015 Accept = if_write & if_write_ce & if_full_n; pop = if_read & if_read_ce & if_empty_n.
REQ-016 Credit counter: -1 on accept, +1 on returned credit, unchanged when both or neither.
REQ-017 if_full_n is registered: next value = (next credit_cnt != 0).
REQ-018 Forward path: LEVEL registered {valid,data} stages from accept to receive-FIFO push.
REQ-019 Return path: LEVEL registered single-bit stages carrying each pop back as one credit.
REQ-020 LEVEL=0: forward and return paths combinational; counter and FIFO unchanged.
REQ-021 Latency: accept at cycle t -> if_empty_n high, word on if_dout at t+LEVEL+1 (if FIFO was empty).
REQ-022 Pop at cycle t -> credit_cnt incremented at t+LEVEL+1.
REQ-023 Receive FIFO: FWFT, FIFO_DEPTH entries, order preserving, push and pop in same cycle allowed at any occupancy.
REQ-024 Push to full FIFO without same-cycle pop: word dropped, err_overflow set until reset (unreachable in correct use).
REQ-025 Sustained throughput one word per cycle when reader always ready.
REQ-026 Credit counter never exceeds FIFO_DEPTH nor goes below 0.

Reset
REQ-027 On reset: credit_cnt=FIFO_DEPTH, if_full_n=1, if_empty_n=0, if_dout=0, err_overflow=0.
REQ-028 On reset: all forward and return pipeline valid bits cleared; in-flight words and credits discarded.
REQ-029 Reset mid-operation takes priority over simultaneous accept or pop in that cycle.

Structure
REQ-030 FIFO_DEPTH and CREDIT_W computation live in shared package relay_station_pkg.
REQ-031 Receive FIFO is sub-module relay_fifo_fwft (DATA_WIDTH, FIFO_DEPTH params, if_* ports plus overflow).
REQ-032 Pipeline stages are generate loops in the top level; no sub-module per stage.

Verification (DATA_WIDTH=32, DEPTH=2, LEVEL=2, FIFO_DEPTH=8)
REQ-033 Reset, write 0xA5 at cycle 0, reader ready -> if_empty_n=1, if_dout=0xA5 at cycle 3; credit back to 8 at cycle 6.
REQ-034 Reader stalled, continuous writes -> exactly 8 accepted, if_full_n=0 after 8th, err_overflow stays 0.
REQ-035 From full, one pop at cycle t -> if_full_n=1 at t+3, exactly one more write accepted.
REQ-036 Stream 100 incrementing words, reader always ready -> one output per cycle after fill, order 0..99, no gaps.
REQ-037 credit_cnt=1 with accept and returning credit same cycle -> credit_cnt stays 1, if_full_n stays 1.
REQ-038 Reset asserted with 5 words in flight -> next cycle if_empty_n=0, credit_cnt=8, no stale word emitted later.
